wb_grf_stage: RTL and testbench

- Writeback stage of the five-stage MIPS pipeline. It sits directly downstream of the M/W pipeline register and consumes that register's outputs.
- It selects and extends the result, decides whether the write commits, and writes the 32x32 general register file.
- It serves the D-stage register reads with write-before-read bypass, and exports the W-stage write triple for forwarding.
- It keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 59 +++++
 rtl/wb_grf_core.sv | 45 ++++
 rtl/wb_grf_stage.sv | 117 +++++++++++
 tb/tb_wb_grf_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared decode constants, source/load-type encodings and load extension
// helper for the writeback stage.
package wb_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] LB    = 6'b100000;
  localparam logic [5:0] LBU   = 6'b100100;
  localparam logic [5:0] LH    = 6'b100001;
  localparam logic [5:0] LHU   = 6'b100101;
  localparam logic [5:0] JAL   = 6'b000011;

  localparam logic [5:0] JALR  = 6'b001001;
  localparam logic [5:0] JR    = 6'b001000;
  localparam logic [5:0] MOVZ  = 6'b001010;

  // I-type ALU opcodes occupy a contiguous range (addi .. lui).
  localparam logic [5:0] IALU_LO = 6'b001000;
  localparam logic [5:0] IALU_HI = 6'b001111;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_DM  = 2'd1,
    SRC_PC8 = 2'd2
  } wb_src_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  // Halfword selection only looks at off[1]; misaligned off[0] is ignored.
  function automatic logic [31:0] load_extend(input ld_type_e   ld_type,
                                              input logic [31:0] word,
                                              input logic [1:0]  off);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'd0, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_grf_core.sv
// 32x32 general register file: async clear, one write port, two read ports
// with write-before-read bypass so a same-cycle write is visible at once.
// Register $0 has no storage and always reads zero.
module grf_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [1:31];

  // Storage: cleared asynchronously, written on the edge when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port A: bypass the in-flight write, else the stored value.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != 5'd0) begin
      if (we && (waddr == raddr_a)) rdata_a = wdata;
      else                          rdata_a = regs[raddr_a];
    end
  end

  // Read port B: same bypass rule as port A.
  always_comb begin
    rdata_b = '0;
    if (raddr_b != 5'd0) begin
      if (we && (waddr == raddr_b)) rdata_b = wdata;
      else                          rdata_b = regs[raddr_b];
    end
  end

endmodule

// File: rtl/wb_grf_stage.sv
// MIPS writeback stage: decodes the W-stage instruction, extends loaded data,
// selects the write-back source, gates the register write, owns the register
// file and counts retired instructions.
// Optional macro GRF_TRACE_EN: prints one trace line per committed write.
module wb_grf_stage
  import wb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_W,
  input  logic [31:0] data_dm_W,
  input  logic [31:0] data_alu_W,
  input  logic [31:0] pcout_W,
  input  logic [4:0]  writereg_W,
  input  logic        movz_W_output,
  input  logic        exc_W,
  input  logic [4:0]  rs_addr_D,
  input  logic [4:0]  rt_addr_D,
  output logic [31:0] rs_data_D,
  output logic [31:0] rt_data_D,
  output logic        wb_we_W,
  output logic [4:0]  wb_addr_W,
  output logic [31:0] wb_data_W,
  output logic [31:0] retire_cnt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       dec_writes;
  logic       is_movz;
  wb_src_e    src;
  ld_type_e   ld_type;
  logic [31:0] sel_data;
  logic        retire;

  assign opcode = instr_W[31:26];
  assign funct  = instr_W[5:0];

  // Decode: does this instruction write a register, and from which source.
  always_comb begin
    dec_writes = 1'b0;
    is_movz    = 1'b0;
    src        = SRC_ALU;
    ld_type    = LD_W;
    if (instr_W != 32'd0) begin
      case (opcode)
        LW:  begin dec_writes = 1'b1; src = SRC_DM; ld_type = LD_W;  end
        LB:  begin dec_writes = 1'b1; src = SRC_DM; ld_type = LD_B;  end
        LBU: begin dec_writes = 1'b1; src = SRC_DM; ld_type = LD_BU; end
        LH:  begin dec_writes = 1'b1; src = SRC_DM; ld_type = LD_H;  end
        LHU: begin dec_writes = 1'b1; src = SRC_DM; ld_type = LD_HU; end
        JAL: begin dec_writes = 1'b1; src = SRC_PC8; end
        RTYPE: begin
          if (funct == JALR) begin
            dec_writes = 1'b1;
            src        = SRC_PC8;
          end else if (funct != JR) begin
            dec_writes = 1'b1;
            is_movz    = (funct == MOVZ);
          end
        end
        default: begin
          if ((opcode >= IALU_LO) && (opcode <= IALU_HI)) dec_writes = 1'b1;
        end
      endcase
    end
  end

  // Source mux: link address, extended load data or ALU result.
  always_comb begin
    case (src)
      SRC_PC8: sel_data = pcout_W + 32'd8;
      SRC_DM:  sel_data = load_extend(ld_type, data_dm_W, data_alu_W[1:0]);
      default: sel_data = data_alu_W;
    endcase
  end

  // Commit gate; a failed movz condition turns the write into a no-op.
  always_comb begin
    wb_we_W   = dec_writes && !exc_W && (writereg_W != 5'd0) &&
                (!is_movz || movz_W_output);
    wb_addr_W = wb_we_W ? writereg_W : 5'd0;
    wb_data_W = wb_we_W ? sel_data   : 32'd0;
  end

  grf_core u_grf_core (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we_W),
    .waddr   (wb_addr_W),
    .wdata   (wb_data_W),
    .raddr_a (rs_addr_D),
    .raddr_b (rt_addr_D),
    .rdata_a (rs_data_D),
    .rdata_b (rt_data_D)
  );

  // Bubbles (nop or PC below the boot address) and squashed slots do not retire.
  assign retire = (instr_W != 32'd0) && !exc_W && (pcout_W >= RESET_PC);

  // Retired-instruction counter, free-running with natural wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
  end

`ifdef GRF_TRACE_EN
  // Simulation trace of every committed register write.
  always @(posedge clk) begin
    if (reset && wb_we_W)
      $display("@%08h: $%2d <= %08h", pcout_W, wb_addr_W, wb_data_W);
  end
`endif

endmodule

// File: tb/tb_wb_grf_stage.sv
module tb_wb_grf_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_W = '0, data_dm_W = '0, data_alu_W = '0, pcout_W = '0;
  logic [4:0]  writereg_W = '0, rs_addr_D = '0, rt_addr_D = '0;
  logic        movz_W_output = 1'b0, exc_W = 1'b0;
  logic [31:0] rs_data_D, rt_data_D, wb_data_W, retire_cnt;
  logic        wb_we_W;
  logic [4:0]  wb_addr_W;

  int checks = 0;
  int failures = 0;

  wb_grf_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .instr_W(instr_W), .data_dm_W(data_dm_W),
    .data_alu_W(data_alu_W), .pcout_W(pcout_W), .writereg_W(writereg_W),
    .movz_W_output(movz_W_output), .exc_W(exc_W), .rs_addr_D(rs_addr_D),
    .rt_addr_D(rt_addr_D), .rs_data_D(rs_data_D), .rt_data_D(rt_data_D),
    .wb_we_W(wb_we_W), .wb_addr_W(wb_addr_W), .wb_data_W(wb_data_W),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_rf [32];
  logic [31:0] ref_cnt;

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s (%s) actual=%08h required=%08h", name, tag, act, req);
    end
  endtask

  // Monitor: the DUT presents one W-stage slot per cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_we",      e.tag, {31'd0, wb_we_W}, {31'd0, e.we});
        chk("wb_addr",    e.tag, {27'd0, wb_addr_W}, {27'd0, e.addr});
        chk("wb_data",    e.tag, wb_data_W, e.data);
        chk("rs_data",    e.tag, rs_data_D, e.rs);
        chk("rt_data",    e.tag, rt_data_D, e.rt);
        chk("retire_cnt", e.tag, retire_cnt, e.rc);
      end
    end
  end

  // Reference: what should be written, computed from the ISA rules directly.
  function automatic void ref_wb(input logic [31:0] instr, input logic [31:0] dm,
                                 input logic [31:0] alu, input logic [31:0] pc,
                                 input logic movz, output logic writes,
                                 output logic [31:0] val);
    int unsigned off, b, h;
    logic [5:0] op, fn;
    op = instr[31:26];
    fn = instr[5:0];
    off = int'(alu[1:0]);
    b = (dm >> (8 * off)) & 32'hFF;
    h = (dm >> (16 * (off / 2))) & 32'hFFFF;
    writes = 1'b0;
    val = 32'd0;
    if (instr == 32'd0) return;
    if (op == 6'b100011) begin writes = 1; val = dm; end
    else if (op == 6'b100000) begin writes = 1; val = (b >= 128) ? b - 256 : b; end
    else if (op == 6'b100100) begin writes = 1; val = b; end
    else if (op == 6'b100001) begin writes = 1; val = (h >= 32768) ? h - 65536 : h; end
    else if (op == 6'b100101) begin writes = 1; val = h; end
    else if (op == 6'b000011) begin writes = 1; val = pc + 8; end
    else if (op >= 8 && op <= 15) begin writes = 1; val = alu; end
    else if (op == 0) begin
      if (fn == 6'b001001) begin writes = 1; val = pc + 8; end
      else if (fn == 6'b001010) begin writes = movz; val = alu; end
      else if (fn != 6'b001000) begin writes = 1; val = alu; end
    end
  endfunction

  // Drive one W-stage slot (call just after a rising edge) and queue its expectation.
  task automatic issue(input string tag, input logic [31:0] instr,
                       input logic [31:0] dm, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] wreg,
                       input logic movz, input logic exc,
                       input logic [4:0] rsa, input logic [4:0] rta);
    exp_t e;
    logic writes;
    logic [31:0] val;
    instr_W = instr; data_dm_W = dm; data_alu_W = alu; pcout_W = pc;
    writereg_W = wreg; movz_W_output = movz; exc_W = exc;
    rs_addr_D = rsa; rt_addr_D = rta;
    ref_wb(instr, dm, alu, pc, movz, writes, val);
    e.tag  = tag;
    e.we   = writes && !exc && (wreg != 0);
    e.addr = e.we ? wreg : 5'd0;
    e.data = e.we ? val : 32'd0;
    e.rs   = (rsa == 0) ? 32'd0 : (e.we && wreg == rsa) ? val : ref_rf[rsa];
    e.rt   = (rta == 0) ? 32'd0 : (e.we && wreg == rta) ? val : ref_rf[rta];
    e.rc   = ref_cnt;
    sb.push_back(e);
    if (e.we) ref_rf[wreg] = val;
    if (instr != 0 && !exc && pc >= RESET_PC) ref_cnt = ref_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    ref_cnt = 32'd0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] ops [10];
    logic [5:0] fns [6];
    ops = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b000011, 6'b101011, 6'b000100, 6'b000000, 6'b001101};
    fns = '{6'b100001, 6'b001001, 6'b001000, 6'b001010, 6'b100101, 6'b000000};
    r = $urandom();
    case ($urandom_range(0, 12))
      10: r[31:26] = 6'($urandom_range(8, 15));
      11: r = 32'd0;
      12: begin r[31:26] = 6'b000000; r[5:0] = fns[$urandom_range(0, 5)]; end
      default: r[31:26] = ops[$urandom_range(0, 9)];
    endcase
    if (r[31:26] == 6'b000000 && $urandom_range(0, 1) == 1)
      r[5:0] = fns[$urandom_range(0, 5)];
    return r;
  endfunction

  localparam logic [31:0] DM = 32'h80FF_7F01;

  initial begin
    int budget;
    clear_model();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    step(); issue("reset_read", 32'd0, 0, 0, RESET_PC, 5'd0, 0, 0, 5'd5, 5'd31);
    step(); issue("ori_bypass", {6'b001101, 5'd0, 5'd8, 16'h1234}, 0, 32'h1234,
                  32'h3000, 5'd8, 0, 0, 5'd8, 5'd0);
    step(); issue("ori_stored", 32'd0, 0, 0, 32'h3004, 5'd0, 0, 0, 5'd8, 5'd8);
    step(); issue("lb_off2",  {6'b100000, 26'h0}, DM, 32'h100E, 32'h3008, 5'd10, 0, 0, 5'd10, 5'd8);
    step(); issue("lb_off3",  {6'b100000, 26'h0}, DM, 32'h100F, 32'h300C, 5'd11, 0, 0, 5'd11, 5'd10);
    step(); issue("lbu_off3", {6'b100100, 26'h0}, DM, 32'h1003, 32'h3010, 5'd12, 0, 0, 5'd12, 5'd11);
    step(); issue("lh_off2",  {6'b100001, 26'h0}, DM, 32'h1002, 32'h3014, 5'd13, 0, 0, 5'd13, 5'd12);
    step(); issue("lh_off3",  {6'b100001, 26'h0}, DM, 32'h1003, 32'h3018, 5'd14, 0, 0, 5'd14, 5'd0);
    step(); issue("jal",      {6'b000011, 26'h0}, 0, 32'h55, 32'h3010, 5'd31, 0, 0, 5'd31, 5'd13);
    step(); issue("movz_no",  {6'b0, 5'd1, 5'd0, 5'd15, 5'd0, 6'b001010}, 0, 32'hAAAA, 32'h3020, 5'd15, 0, 0, 5'd15, 5'd31);
    step(); issue("movz_yes", {6'b0, 5'd1, 5'd0, 5'd15, 5'd0, 6'b001010}, 0, 32'hBBBB, 32'h3024, 5'd15, 1, 0, 5'd15, 5'd0);
    step(); issue("wr_zero",  {6'b0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001}, 0, 32'hDEAD, 32'h3028, 5'd0, 0, 0, 5'd0, 5'd15);
    step(); issue("exc",      {6'b001101, 5'd0, 5'd16, 16'h7777}, 0, 32'h7777, 32'h302C, 5'd16, 0, 1, 5'd16, 5'd0);
    step(); issue("bubble_pc", {6'b001101, 5'd0, 5'd17, 16'h1}, 0, 32'h1, 32'h0000_2FFC, 5'd17, 0, 0, 5'd17, 5'd16);
    step(); issue("after_exc", 32'd0, 0, 0, 32'h3030, 5'd0, 0, 0, 5'd16, 5'd17);

    // Counter wrap: preload all-ones, then one retiring store.
    step();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    ref_cnt = 32'hFFFF_FFFF;
    issue("sw_wrap", {6'b101011, 26'h0}, 0, 32'h100, 32'h3034, 5'd3, 0, 0, 5'd0, 5'd0);
    step(); issue("wrapped", 32'd0, 0, 0, 32'h3038, 5'd0, 0, 0, 5'd0, 5'd0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h2FFF))
                                       : RESET_PC + 32'($urandom_range(0, 32'hFFFF));
      step();
      issue("random", rand_instr(), $urandom(), $urandom(), pc,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    // Reset in the middle of a write: the write is lost, file and counter clear.
    step(); issue("pre_reset", {6'b001101, 5'd0, 5'd9, 16'h4242}, 0, 32'h4242,
                  32'h3100, 5'd9, 0, 0, 5'd9, 5'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1 reset = 1'b1;
    issue("post_reset", 32'd0, 0, 0, 32'h3104, 5'd0, 0, 0, 5'd9, 5'd31);
    step(); issue("post_reset2", {6'b001101, 5'd0, 5'd9, 16'h0099}, 0, 32'h99,
                  32'h3108, 5'd9, 0, 0, 5'd0, 5'd9);
    step(); issue("post_reset3", 32'd0, 0, 0, 32'h310C, 5'd0, 0, 0, 5'd9, 5'd0);
    step();
    instr_W = 32'd0; writereg_W = 5'd0;

    budget = 0;
    while (sb.size() > 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
